// File: rtl/secventiator_intersectie_pkg.sv
// Shared types for the intersection sequencer: light codes, phase enum and
// the phase-to-lamp-code mapping used by the registered outputs.
package intersectie_pkg;

   localparam logic [1:0] COD_ROSU       = 2'b00;
   localparam logic [1:0] COD_GALBEN     = 2'b01;
   localparam logic [1:0] COD_VERDE      = 2'b10;
   localparam logic [1:0] COD_ROSU_TOTAL = 2'b11;

   typedef enum logic [2:0] {
      ROSU_1   = 3'd0,
      N_VERDE  = 3'd1,
      N_GALBEN = 3'd2,
      ROSU_2   = 3'd3,
      E_VERDE  = 3'd4,
      E_GALBEN = 3'd5,
      NOAPTE   = 3'd6
   } faza_t;

   // Packed as {w_n, w_e, tranzit_n, tranzit_e}.
   function automatic logic [5:0] iesiri_faza(input faza_t f);
      logic [5:0] r;
      r = {COD_ROSU_TOTAL, COD_ROSU_TOTAL, 2'b00};
      case (f)
         ROSU_1:   r = {COD_ROSU_TOTAL, COD_ROSU_TOTAL, 2'b00};
         N_VERDE:  r = {COD_VERDE,      COD_ROSU,       2'b00};
         N_GALBEN: r = {COD_GALBEN,     COD_ROSU,       2'b00};
         ROSU_2:   r = {COD_ROSU_TOTAL, COD_ROSU_TOTAL, 2'b00};
         E_VERDE:  r = {COD_ROSU,       COD_VERDE,      2'b00};
         E_GALBEN: r = {COD_ROSU,       COD_GALBEN,     2'b00};
         NOAPTE:   r = {COD_GALBEN,     COD_GALBEN,     2'b11};
         default:  r = {COD_ROSU_TOTAL, COD_ROSU_TOTAL, 2'b00};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/secventiator_intersectie_if.sv
// Sensor/tick inputs and lamp-code outputs of the sequencer, bundled.
interface secventiator_intersectie_if;

   logic       tick_i;
   logic       cerere_e_i;
   logic       mod_noapte_i;
   logic [1:0] w_n_o;
   logic [1:0] w_e_o;
   logic       tranzit_n_o;
   logic       tranzit_e_o;
   logic       enable_o;
   logic [2:0] faza_o;

   // Environment side: drives tick and sensors, observes the codes.
   modport master (
      output tick_i, cerere_e_i, mod_noapte_i,
      input  w_n_o, w_e_o, tranzit_n_o, tranzit_e_o, enable_o, faza_o
   );

   // Sequencer side.
   modport slave (
      input  tick_i, cerere_e_i, mod_noapte_i,
      output w_n_o, w_e_o, tranzit_n_o, tranzit_e_o, enable_o, faza_o
   );

endinterface

// File: rtl/secventiator_intersectie_temporizator.sv
// Phase down-counter: loads T-1 on phase entry, counts ticks, and flags
// expiry on the tick that finds it at zero, so a phase lasts exactly T ticks.
module temporizator_faza #(
   parameter int unsigned     CNT_W     = 8,
   parameter logic [CNT_W-1:0] VAL_RESET = '0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   output logic             expirat
);

   logic [CNT_W-1:0] r_timer;

   // Load has priority over counting; the counter parks at zero.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         r_timer <= VAL_RESET;
      else if (load)
         r_timer <= load_val;
      else if (tick && (r_timer != '0))
         r_timer <= r_timer - 1'b1;
   end

   assign expirat = tick && (r_timer == '0);

endmodule

// File: rtl/secventiator_intersectie.sv
// Two-axis intersection phase sequencer with E-axis demand hold and night mode.
module secventiator_intersectie
   import intersectie_pkg::*;
#(
   parameter int unsigned T_GREEN   = 8,
   parameter int unsigned T_YELLOW  = 3,
   parameter int unsigned T_ALL_RED = 2,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   secventiator_intersectie_if.slave bus
);

   localparam logic [CNT_W-1:0] L_GREEN   = CNT_W'(T_GREEN - 1);
   localparam logic [CNT_W-1:0] L_YELLOW  = CNT_W'(T_YELLOW - 1);
   localparam logic [CNT_W-1:0] L_ALL_RED = CNT_W'(T_ALL_RED - 1);

   faza_t            r_stare;
   faza_t            w_stare_urm;
   logic             r_pornit;
   logic             r_cerere_q;
   logic [1:0]       r_w_n;
   logic [1:0]       r_w_e;
   logic             r_tranzit_n;
   logic             r_tranzit_e;
   logic             r_enable;
   logic             w_tick;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_expirat;
   logic             w_intra_e_verde;
   logic [5:0]       w_iesiri;

   // Ticks are ignored on the start-pulse edge so ROSU_1 keeps its full length.
   assign w_tick = bus.tick_i & r_pornit;

   temporizator_faza #(
      .CNT_W     (CNT_W),
      .VAL_RESET (L_ALL_RED)
   ) u_temporizator (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .load     (w_load),
      .load_val (w_load_val),
      .tick     (w_tick),
      .expirat  (w_expirat)
   );

   // Next phase and timer reload; night request overrides any expiry.
   always_comb begin
      w_stare_urm = r_stare;
      w_load      = 1'b0;
      w_load_val  = L_ALL_RED;
      if (r_stare == NOAPTE) begin
         if (w_tick && !bus.mod_noapte_i) begin
            w_stare_urm = ROSU_1;
            w_load      = 1'b1;
            w_load_val  = L_ALL_RED;
         end
      end else if (w_tick && bus.mod_noapte_i) begin
         w_stare_urm = NOAPTE;
      end else if (w_expirat) begin
         w_load = 1'b1;
         case (r_stare)
            ROSU_1: begin
               w_stare_urm = N_VERDE;
               w_load_val  = L_GREEN;
            end
            N_VERDE: begin
               // Without E demand, green is simply restarted.
               w_stare_urm = r_cerere_q ? N_GALBEN : N_VERDE;
               w_load_val  = r_cerere_q ? L_YELLOW : L_GREEN;
            end
            N_GALBEN: begin
               w_stare_urm = ROSU_2;
               w_load_val  = L_ALL_RED;
            end
            ROSU_2: begin
               w_stare_urm = E_VERDE;
               w_load_val  = L_GREEN;
            end
            E_VERDE: begin
               w_stare_urm = E_GALBEN;
               w_load_val  = L_YELLOW;
            end
            E_GALBEN: begin
               w_stare_urm = ROSU_1;
               w_load_val  = L_ALL_RED;
            end
            default: begin
               w_stare_urm = ROSU_1;
               w_load_val  = L_ALL_RED;
            end
         endcase
      end
   end

   assign w_intra_e_verde = (w_stare_urm == E_VERDE) && (r_stare != E_VERDE);
   assign w_iesiri        = iesiri_faza(w_stare_urm);

   // Phase register, demand latch and registered outputs derived from the next phase.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_stare     <= ROSU_1;
         r_pornit    <= 1'b0;
         r_cerere_q  <= 1'b0;
         r_w_n       <= COD_ROSU_TOTAL;
         r_w_e       <= COD_ROSU_TOTAL;
         r_tranzit_n <= 1'b0;
         r_tranzit_e <= 1'b0;
         r_enable    <= 1'b0;
      end else begin
         r_stare     <= w_stare_urm;
         r_pornit    <= 1'b1;
         // A request in the same cycle as the E_VERDE entry is kept.
         r_cerere_q  <= bus.cerere_e_i | (r_cerere_q & ~w_intra_e_verde);
         r_w_n       <= w_iesiri[5:4];
         r_w_e       <= w_iesiri[3:2];
         r_tranzit_n <= w_iesiri[1];
         r_tranzit_e <= w_iesiri[0];
         r_enable    <= (w_stare_urm != r_stare) | ~r_pornit;
      end
   end

   assign bus.w_n_o       = r_w_n;
   assign bus.w_e_o       = r_w_e;
   assign bus.tranzit_n_o = r_tranzit_n;
   assign bus.tranzit_e_o = r_tranzit_e;
   assign bus.enable_o    = r_enable;
   assign bus.faza_o      = r_stare;

endmodule

// File: tb/tb_secventiator_intersectie.sv
// Directed bench for the intersection sequencer (T_GREEN=4, T_YELLOW=2, T_ALL_RED=1).
module tb_secventiator_intersectie;

   logic clk = 1'b0;
   logic rst_n;
   int   n_assert = 0;
   int   n_fail   = 0;

   secventiator_intersectie_if bus_if ();

   secventiator_intersectie #(
      .T_GREEN   (4),
      .T_YELLOW  (2),
      .T_ALL_RED (1),
      .CNT_W     (8)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      n_assert++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // {faza, w_n, w_e, enable}
   function automatic logic [7:0] obs();
      return {bus_if.faza_o, bus_if.w_n_o, bus_if.w_e_o, bus_if.enable_o};
   endfunction

   function automatic logic [7:0] trz();
      return {6'd0, bus_if.tranzit_n_o, bus_if.tranzit_e_o};
   endfunction

   // Hand table of phase -> {faza, w_n, w_e} with the expected enable appended.
   function automatic logic [7:0] ev(input int f, input logic en);
      logic [6:0] v;
      case (f)
         0:       v = {3'd0, 2'b11, 2'b11};
         1:       v = {3'd1, 2'b10, 2'b00};
         2:       v = {3'd2, 2'b01, 2'b00};
         3:       v = {3'd3, 2'b11, 2'b11};
         4:       v = {3'd4, 2'b00, 2'b10};
         5:       v = {3'd5, 2'b00, 2'b01};
         6:       v = {3'd6, 2'b01, 2'b01};
         default: v = 7'h7f;
      endcase
      return {v, en};
   endfunction

   function automatic logic activ(input logic [1:0] c);
      return (c == 2'b10) || (c == 2'b01);
   endfunction

   // Conflicting green/yellow on both axes must never appear outside night mode.
   always @(negedge clk) begin
      if (rst_n && bus_if.faza_o != 3'd6) begin
         n_assert++;
         assert (!(activ(bus_if.w_n_o) && activ(bus_if.w_e_o)))
         else begin
            n_fail++;
            $error("FAIL safety observed=%b/%b expected=not both active", bus_if.w_n_o, bus_if.w_e_o);
         end
      end
   end

   initial begin
      int   exp_f  [14] = '{1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5, 5, 0, 1};
      logic exp_en [14] = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1};
      int   n_en;
      int   ef;
      logic een;
      logic gasit;

      rst_n               = 1'b1;
      bus_if.tick_i       = 1'b1;
      bus_if.cerere_e_i   = 1'b1;
      bus_if.mod_noapte_i = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset", obs(), ev(0, 1'b0));
      chk("reset_tranzit", trz(), 8'd0);

      #10 rst_n = 1'b1;
      cyc();
      chk("start_pulse", obs(), ev(0, 1'b1));
      cyc();
      chk("first_n_verde", obs(), ev(1, 1'b1));

      n_en = 0;
      for (int i = 0; i < 14; i++) begin
         cyc();
         chk($sformatf("period_edge%0d", i + 3), obs(), ev(exp_f[i], exp_en[i]));
         n_en += int'(bus_if.enable_o);
      end
      chk("enable_per_period", 8'(n_en), 8'd6);

      gasit = 1'b0;
      for (int i = 0; i < 20 && !gasit; i++) begin
         cyc();
         if (bus_if.faza_o == 3'd4) gasit = 1'b1;
      end
      chk("reach_e_verde", {7'd0, gasit}, 8'd1);

      bus_if.mod_noapte_i = 1'b1;
      cyc();
      chk("night_entry", obs(), ev(6, 1'b1));
      chk("night_tranzit", trz(), 8'd3);
      cyc();
      chk("night_hold", obs(), ev(6, 1'b0));
      bus_if.mod_noapte_i = 1'b0;
      cyc();
      chk("night_exit", obs(), ev(0, 1'b1));
      chk("night_exit_tranzit", trz(), 8'd0);
      cyc();
      chk("after_night", obs(), ev(1, 1'b1));

      repeat (3) cyc();
      cyc();
      chk("n_galben_before_reset", obs(), ev(2, 1'b1));
      #2 rst_n = 1'b0;
      bus_if.cerere_e_i = 1'b0;
      #1;
      chk("async_reset", obs(), ev(0, 1'b0));
      chk("async_reset_tranzit", trz(), 8'd0);
      cyc();
      chk("reset_held", obs(), ev(0, 1'b0));
      #3 rst_n = 1'b1;

      cyc();
      chk("no_demand_start", obs(), ev(0, 1'b1));
      cyc();
      chk("no_demand_n_verde", obs(), ev(1, 1'b1));
      for (int i = 0; i < 12; i++) begin
         cyc();
         chk($sformatf("demand_hold%0d", i), obs(), ev(1, 1'b0));
      end
      bus_if.cerere_e_i = 1'b1;
      cyc();
      chk("pulse_edge15", obs(), ev(1, 1'b0));
      bus_if.cerere_e_i = 1'b0;
      cyc();
      chk("pulse_edge16", obs(), ev(1, 1'b0));
      cyc();
      chk("pulse_edge17", obs(), ev(1, 1'b0));
      cyc();
      chk("pulse_n_galben", obs(), ev(2, 1'b1));
      cyc();
      chk("pulse_edge19", obs(), ev(2, 1'b0));
      cyc();
      chk("pulse_rosu_2", obs(), ev(3, 1'b1));
      cyc();
      chk("pulse_e_verde", obs(), ev(4, 1'b1));
      repeat (7) cyc();
      chk("demand_cleared_n_verde", obs(), ev(1, 1'b1));
      repeat (4) cyc();
      chk("demand_cleared_hold", obs(), ev(1, 1'b0));

      rst_n = 1'b0;
      bus_if.cerere_e_i = 1'b1;
      bus_if.tick_i     = 1'b0;
      #4 rst_n = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         bus_if.tick_i = (i % 3 == 0);
         cyc();
         if (i <= 2)       ef = 0;
         else if (i <= 14) ef = 1;
         else if (i <= 20) ef = 2;
         else if (i <= 23) ef = 3;
         else              ef = 4;
         een = (i == 1) || (i == 3) || (i == 15) || (i == 21) || (i == 24);
         chk($sformatf("slow_tick_edge%0d", i), obs(), ev(ef, een));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/secventiator_intersectie.md
Name: secventiator_intersectie

Overview:
- Phase sequencer for a two-axis intersection: North-South (N) and East-West (E).
- Generates the 2-bit light-state codes, the transit (flashing/maintenance) flags and an update strobe.
- Per-direction lamp controllers consume these outputs and decode them into red/yellow/green lamps.
- Contains the timing, vehicle-demand logic and night mode.

Parameters:
- T_GREEN, 8: green duration in ticks (minimum green for N).
- T_YELLOW, 3: yellow duration in ticks.
- T_ALL_RED, 2: all-red clearance duration in ticks.
- CNT_W, 8: timer width; every duration must satisfy 1 ≤ T_x ≤ 2^CNT_W.

Ports:
- clk_i, in, 1: clock.
- rst_n_i, in, 1: reset, asynchronous, active-low.
- tick_i, in, 1: single-cycle time strobe from the prescaler; timing advances only on tick_i=1.
- cerere_e_i, in, 1: E-axis vehicle-present sensor (level or pulse).
- mod_noapte_i, in, 1: night/maintenance request.
- w_n_o, out, 2: N light code (00 red, 01 yellow, 10 green, 11 all-red).
- w_e_o, out, 2: E light code, same encoding.
- tranzit_n_o, out, 1: N transit flag (forces yellow at the receiver).
- tranzit_e_o, out, 1: E transit flag.
- enable_o, out, 1: one-cycle update strobe.
- faza_o, out, 3: current FSM state, for debug.

Behaviour:
- All outputs registered.
- Reset values: state=ROSU_1, timer=T_ALL_RED-1, cerere_q=0, w_n_o=11, w_e_o=11, tranzit_*=0, enable_o=0, faza_o=ROSU_1.
- Start pulse: first clk_i edge after rst_n_i deassertion drives enable_o=1 for one cycle, codes unchanged (11/11), so receivers leave their reset red.
- States, with outputs (w_n/w_e, tranzit_n/tranzit_e):
  - ROSU_1: 11/11, 0/0.
  - N_VERDE: 10/00.
  - N_GALBEN: 01/00.
  - ROSU_2: 11/11.
  - E_VERDE: 00/10.
  - E_GALBEN: 00/01.
  - NOAPTE: 01/01, tranzit 1/1.
- Timer rules:
  - Down-counter loaded with T_x-1 on entry to a timed state.
  - Decrements only when tick_i=1 and timer≠0.
  - Expiry means tick_i=1 and timer==0, so each state lasts exactly T_x ticks.
  - Transition occurs on the expiry edge; new codes appear on that same edge.
- Transition sequence on expiry: ROSU_1→N_VERDE→N_GALBEN→ROSU_2→E_VERDE→E_GALBEN→ROSU_1.
- Demand hold:
  - At N_VERDE expiry with cerere_q=0, the state stays N_VERDE and the timer reloads T_GREEN-1.
  - No enable_o pulse is generated and the codes do not change.
- cerere_q:
  - Set on any cycle with cerere_e_i=1.
  - Cleared on the edge entering E_VERDE.
  - Set dominates clear in the same cycle, so a request arriving during entry is kept for the next cycle.
- Night mode:
  - mod_noapte_i=1 sampled with tick_i=1 in any non-NOAPTE state enters NOAPTE at that edge; this overrides any expiry transition in the same cycle.
  - In NOAPTE, mod_noapte_i=0 sampled with tick_i=1 enters ROSU_1 with timer=T_ALL_RED-1.
  - cerere_q keeps its value in NOAPTE.
- enable_o: 1 for exactly one cycle on every edge where the state changes (plus the start pulse); otherwise 0.
- tick_i=0 freezes all timing; the FSM never changes state without a tick (start pulse excepted).
- Reset mid-operation: asynchronous return to reset values, regardless of state or timer.
- Safety invariant: w_n_o and w_e_o never simultaneously in {10, 01} outside NOAPTE. The verifier asserts this.

Decomposition:
- Shared package intersectie_pkg:
  - Light-code constants COD_ROSU=2'b00, COD_GALBEN=2'b01, COD_VERDE=2'b10, COD_ROSU_TOTAL=2'b11.
  - State enum faza_t, 3-bit: ROSU_1=0, N_VERDE=1, N_GALBEN=2, ROSU_2=3, E_VERDE=4, E_GALBEN=5, NOAPTE=6.
- One sub-module, temporizator_faza:
  - Parameter CNT_W; inputs load, load_val, tick; output expirat.
  - Instantiated once in the sequencer.

Test Plan (T_GREEN=4, T_YELLOW=2, T_ALL_RED=1, tick_i=1 every cycle, cerere_e_i=1 held):
- Reset release → enable_o=1 at cycle 1 with 11/11; ROSU_1 at cycle 1, N_VERDE codes 10/00 with enable_o=1 at cycle 2.
- Full cycle → phase lengths 4,2,1,4,2,1 cycles; 6 enable_o pulses per 14-cycle period; safety invariant never violated.
- cerere_e_i=0 from reset → N_VERDE held indefinitely, no enable_o after entry. Then a 1-cycle cerere_e_i pulse → N_GALBEN at the next expiry, then E_VERDE after ROSU_2.
- mod_noapte_i=1 mid E_VERDE → next edge 01/01, tranzit 1/1, enable_o=1. Release → ROSU_1 (11/11), then N_VERDE one tick later.
- tick_i asserted every 3rd cycle → each phase lasts 3× its cycle count; no state change on non-tick cycles.
- rst_n_i low during N_GALBEN → outputs immediately 11/11, enable_o=0, faza_o=0 before the next clk_i edge.
